led_pwm_breather: RTL and testbench

Drives the on-board user LED (PIN13_LED net) with a PWM brightness envelope and replaces the raw counter-bit blink. It sits directly downstream of the board-level free-running timebase. It runs on the 16 MHz board clock and produces a glitch-free LED drive. There are two patterns: hard blink and smooth breathe (ramp up, hold, ramp down, hold).

---
 rtl/led_pwm_breather.sv | 141 ++++++++++++++
 tb/tb_led_pwm_breather.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_breather.sv
// LED PWM breather: drives the user LED with either a hard blink or a smooth
// breathe envelope (hold low, ramp up, hold high, ramp down), modulated by a
// registered PWM whose duty only updates at period boundaries.
module led_pwm_breather #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 62500,
    parameter int HOLD_STEPS = 32
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                enable,
    input  logic                mode,
    output logic                led_out,
    output logic [PWM_BITS-1:0] brightness,
    output logic [1:0]          phase
);

    localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W  = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PWM_BITS-1:0] MAX        = '1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        HOLD_LO = 2'd0,
        RISE    = 2'd1,
        HOLD_HI = 2'd2,
        FALL    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PWM_BITS-1:0] bright_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                step;

    // Envelope advances only on the last prescaler count of an enabled cycle.
    assign step  = enable && (presc == PRESC_LAST);
    assign phase = state;

    // Step prescaler: counts enabled cycles 0..STEP_DIV-1, freezes when disabled.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    // PWM counter, period-boundary duty reload and registered LED drive.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pwm_cnt <= '0;
            duty    <= '0;
            led_out <= 1'b0;
        end else if (enable) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == MAX) begin
                duty <= brightness;
            end
            led_out <= (pwm_cnt < duty);
        end else begin
            led_out <= 1'b0;
        end
    end

    // Envelope state register: phase, brightness and hold counter.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= HOLD_LO;
            brightness <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            brightness <= bright_nxt;
            hold_cnt   <= hold_nxt;
        end
    end

    // Envelope next-state logic; everything holds unless this is a step cycle.
    always_comb begin
        state_nxt  = state;
        bright_nxt = brightness;
        hold_nxt   = hold_cnt;
        if (step) begin
            unique case (state)
                HOLD_LO: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (mode) begin
                            state_nxt = RISE;
                        end else begin
                            bright_nxt = MAX;
                            state_nxt  = HOLD_HI;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                RISE: begin
                    if (brightness == MAX) begin
                        state_nxt = HOLD_HI;
                        hold_nxt  = '0;
                    end else begin
                        bright_nxt = brightness + 1'b1;
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (mode) begin
                            state_nxt = FALL;
                        end else begin
                            bright_nxt = '0;
                            state_nxt  = HOLD_LO;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                FALL: begin
                    if (brightness == '0) begin
                        state_nxt = HOLD_LO;
                        hold_nxt  = '0;
                    end else begin
                        bright_nxt = brightness - 1'b1;
                    end
                end
                default: begin
                    state_nxt = HOLD_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm_breather.sv
// Testbench for led_pwm_breather: a step-schedule reference model checks every
// cycle, a vector table walks blink/breathe/freeze/reset, and hand sequences
// cover reset mid-ramp, step timing, blink duty and mid-ramp mode change.
module tb_led_pwm_breather;

    localparam int PWM_BITS   = 4;
    localparam int STEP_DIV   = 4;
    localparam int HOLD_STEPS = 2;
    localparam int MAXV       = (1 << PWM_BITS) - 1;

    logic                CLOCK;
    logic                RESET;
    logic                enable;
    logic                mode;
    logic                led_out;
    logic [PWM_BITS-1:0] brightness;
    logic [1:0]          phase;

    led_pwm_breather #(
        .PWM_BITS  (PWM_BITS),
        .STEP_DIV  (STEP_DIV),
        .HOLD_STEPS(HOLD_STEPS)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .enable    (enable),
        .mode      (mode),
        .led_out   (led_out),
        .brightness(brightness),
        .phase     (phase)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the envelope is a schedule of (phase, level) values,
    // one per future step, expanded from the pattern rules at each hold expiry.
    typedef struct {
        int ph;
        int b;
    } env_t;

    env_t sched[$];
    int   m_cyc;
    int   m_duty;
    int   m_led;
    int   m_ph;
    int   m_b;

    function automatic void push_n(int ph, int b, int n);
        for (int i = 0; i < n; i++) sched.push_back('{ph, b});
    endfunction

    function automatic void expand(int md);
        if (m_ph == 0) begin
            if (md != 0) begin
                for (int b = 0; b <= MAXV; b++) sched.push_back('{1, b});
            end
            push_n(2, MAXV, HOLD_STEPS);
        end else begin
            if (md != 0) begin
                for (int b = MAXV; b >= 0; b--) sched.push_back('{3, b});
            end
            push_n(0, 0, HOLD_STEPS);
        end
    endfunction

    function automatic void model_step(int rst, int en, int md);
        int   pos;
        env_t e;
        if (rst != 0) begin
            m_cyc  = 0;
            m_duty = 0;
            m_led  = 0;
            m_ph   = 0;
            m_b    = 0;
            sched.delete();
            push_n(0, 0, HOLD_STEPS - 1);
        end else if (en == 0) begin
            m_led = 0;
        end else begin
            pos   = m_cyc % (MAXV + 1);
            m_led = (pos < m_duty) ? 1 : 0;
            if (pos == MAXV) m_duty = m_b;
            if (m_cyc % STEP_DIV == STEP_DIV - 1) begin
                if (sched.size() == 0) expand(md);
                e    = sched.pop_front();
                m_ph = e.ph;
                m_b  = e.b;
            end
            m_cyc++;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_step(int'(RESET), int'(enable), int'(mode));
        #1;
        check("model_led", int'(led_out), m_led);
        check("model_phase", int'(phase), m_ph);
        check("model_brightness", int'(brightness), m_b);
    endtask

    task automatic wait_for(input int ph, input int b, input int budget, input string name);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (int'(phase) == ph && int'(brightness) == b) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (int'(phase) == ph && int'(brightness) == b) ok = 1;
        check(name, ok, 1);
    endtask

    typedef struct {
        logic rst;
        logic en;
        logic md;
        int   cycles;
        int   exp_ph;
        int   exp_b;
        int   chk_led;
        int   exp_led;
    } vec_t;

    vec_t vecs[13];
    int   highs;
    int   left;

    initial begin
        RESET  = 1'b1;
        enable = 1'b0;
        mode   = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0,  2, 0,  0, 1, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0,  7, 0,  0, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0,  1, 2, 15, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0,  8, 0,  0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1,  8, 1,  0, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1,  4, 1,  1, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 50, 1,  1, 1, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1,  4, 1,  2, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 52, 1, 15, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1,  4, 2, 15, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b1,  8, 3, 15, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b1,  4, 3, 14, 0, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b1,  1, 0,  0, 1, 0};

        foreach (vecs[k]) begin
            RESET  = vecs[k].rst;
            enable = vecs[k].en;
            mode   = vecs[k].md;
            for (int c = 0; c < vecs[k].cycles; c++) tick();
            check($sformatf("vec%0d_phase", k), int'(phase), vecs[k].exp_ph);
            check($sformatf("vec%0d_brightness", k), int'(brightness), vecs[k].exp_b);
            if (vecs[k].chk_led != 0)
                check($sformatf("vec%0d_led", k), int'(led_out), vecs[k].exp_led);
        end

        // Blink duty: first period carries duty 0, the next carries duty 15.
        RESET = 1'b1; enable = 1'b1; mode = 1'b0;
        tick();
        RESET = 1'b0;
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            highs += int'(led_out);
        end
        check("blink_duty0_highs", highs, 0);
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            highs += int'(led_out);
        end
        check("blink_duty15_highs", highs, 15);

        // Reset mid-ramp, then first step on the 4th enabled cycle.
        mode = 1'b1;
        wait_for(1, 7, 300, "wait_rise7");
        RESET = 1'b1;
        tick();
        check("rst_phase", int'(phase), 0);
        check("rst_brightness", int'(brightness), 0);
        check("rst_led", int'(led_out), 0);
        tick();
        tick();
        RESET = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check("post_rst_still_holdlo", int'(phase), 0);
        tick();
        check("post_rst_enter_rise", int'(phase), 1);

        // Mode 1->0 mid-RISE: ramp completes, then HOLD_HI drops straight to HOLD_LO.
        wait_for(1, 9, 100, "wait_rise9");
        mode = 1'b0;
        wait_for(2, 15, 100, "modechg_reach_holdhi");
        left = 50;
        while (int'(phase) == 2 && left > 0) begin
            tick();
            left--;
        end
        check("modechg_no_fall_phase", int'(phase), 0);
        check("modechg_brightness", int'(brightness), 0);

        // Randomized traffic against the model.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 63) == 0) mode = ~mode;
            RESET = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
